bitslip_align_ctrl: RTL and testbench

- Training-phase controller for the lane_bitslip datapath.
- On start, it takes lanes one at a time and checks the post-slip rise/fall pair against a fixed training pattern.
- On a mismatch it issues single-cycle bitslip pulses until the lane locks or the retry budget runs out.
- It sits between lane_bitslip outputs (observed) and lane_bitslip bitslip_pulse (driven), all in the dco_clk domain.

---
 rtl/adc_fe_pkg.sv | 26 ++
 rtl/align_pattern_checker.sv | 40 ++++
 rtl/bitslip_align_ctrl.sv | 145 ++++++++++++++
 tb/tb_bitslip_align_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fe_pkg.sv
// Shared front-end definitions: alignment FSM states, default training constants
// and a counter-width helper.
package adc_fe_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StCheck  = 3'd2,
    StSlip   = 3'd3,
    StNext   = 3'd4,
    StDone   = 3'd5
  } align_state_e;

  localparam int unsigned ALIGN_SETTLE_CYCLES = 4;
  localparam int unsigned ALIGN_CHECK_CYCLES  = 8;
  localparam int unsigned ALIGN_MAX_SLIPS     = 3;

  localparam logic TRAIN_EXP_RISE = 1'b1;
  localparam logic TRAIN_EXP_FALL = 1'b0;

  // Width needed to hold 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/align_pattern_checker.sv
// Compares the selected lane's rise/fall pair to the training pattern and counts
// consecutive matches; o_lock fires on the match that completes the run.
module align_pattern_checker
  import adc_fe_pkg::*;
#(
  parameter int unsigned CHECK_CYCLES = ALIGN_CHECK_CYCLES
) (
  input  logic dco_clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_rise,
  input  logic i_fall,
  input  logic i_exp_rise,
  input  logic i_exp_fall,
  output logic o_match,
  output logic o_lock
);

  localparam int unsigned CW = cnt_w(CHECK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_match;

  assign w_match = (i_rise == i_exp_rise) && (i_fall == i_exp_fall);
  assign o_match = w_match;
  assign o_lock  = i_en && w_match && (r_cnt == CW'(CHECK_CYCLES - 1));

  // A mismatch restarts the run so only consecutive matches count.
  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_match ? r_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/bitslip_align_ctrl.sv
// Training-phase sequencer: walks the lanes, checks each against the training
// pattern and issues single-cycle bitslip pulses until lock or retry exhaustion.
module bitslip_align_ctrl
  import adc_fe_pkg::*;
#(
  parameter int unsigned LANES         = 1,
  parameter int unsigned SETTLE_CYCLES = ALIGN_SETTLE_CYCLES,
  parameter int unsigned CHECK_CYCLES  = ALIGN_CHECK_CYCLES,
  parameter int unsigned MAX_SLIPS     = ALIGN_MAX_SLIPS,
  parameter logic        EXP_RISE      = TRAIN_EXP_RISE,
  parameter logic        EXP_FALL      = TRAIN_EXP_FALL
) (
  input  logic             dco_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LANES-1:0] out_rise,
  input  logic [LANES-1:0] out_fall,
  output logic [LANES-1:0] bitslip_pulse,
  output logic [LANES-1:0] lane_locked,
  output logic [LANES-1:0] lane_err,
  output logic             busy,
  output logic             done,
  output logic             fail
);

  localparam int unsigned LW  = cnt_w(LANES - 1);
  localparam int unsigned SW  = cnt_w(SETTLE_CYCLES);
  localparam int unsigned SLW = cnt_w(MAX_SLIPS);

  align_state_e     r_state;
  logic [LW-1:0]    r_lane;
  logic [SW-1:0]    r_settle_cnt;
  logic [SLW-1:0]   r_slip_cnt;
  logic [LANES-1:0] r_pulse;
  logic [LANES-1:0] r_locked;
  logic [LANES-1:0] r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;

  logic w_rise;
  logic w_fall;
  logic w_in_check;
  logic w_match;
  logic w_lock;

  assign w_rise     = out_rise[r_lane];
  assign w_fall     = out_fall[r_lane];
  assign w_in_check = (r_state == StCheck);

  align_pattern_checker #(
    .CHECK_CYCLES (CHECK_CYCLES)
  ) u_checker (
    .dco_clk    (dco_clk),
    .rst        (rst),
    .i_clear    (!w_in_check),
    .i_en       (w_in_check),
    .i_rise     (w_rise),
    .i_fall     (w_fall),
    .i_exp_rise (EXP_RISE),
    .i_exp_fall (EXP_FALL),
    .o_match    (w_match),
    .o_lock     (w_lock)
  );

  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_lane       <= '0;
      r_settle_cnt <= '0;
      r_slip_cnt   <= '0;
      r_pulse      <= '0;
      r_locked     <= '0;
      r_err        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      // Pulse is only ever set on the CHECK->SLIP edge, so it lasts one cycle.
      r_pulse <= '0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_locked     <= '0;
            r_err        <= '0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_busy       <= 1'b1;
            r_lane       <= '0;
            r_slip_cnt   <= '0;
            r_settle_cnt <= '0;
            r_state      <= StSettle;
          end
        end
        StSettle: begin
          r_settle_cnt <= r_settle_cnt + 1'b1;
          if (r_settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_lock) begin
            r_locked[r_lane] <= 1'b1;
            r_state          <= StNext;
          end else if (!w_match) begin
            if (r_slip_cnt < SLW'(MAX_SLIPS)) begin
              r_pulse[r_lane] <= 1'b1;
              r_state         <= StSlip;
            end else begin
              r_err[r_lane] <= 1'b1;
              r_fail        <= 1'b1;
              r_state       <= StNext;
            end
          end
        end
        StSlip: begin
          r_slip_cnt   <= r_slip_cnt + 1'b1;
          r_settle_cnt <= '0;
          r_state      <= StSettle;
        end
        StNext: begin
          if (r_lane == LW'(LANES - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_lane       <= r_lane + 1'b1;
            r_slip_cnt   <= '0;
            r_settle_cnt <= '0;
            r_state      <= StSettle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bitslip_pulse = r_pulse;
  assign lane_locked   = r_locked;
  assign lane_err      = r_err;
  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Scoreboard bench for bitslip_align_ctrl with a behavioural lane_bitslip model in loop.
module tb_bitslip_align_ctrl;

  localparam int unsigned LANES = 2;

  logic             dco_clk = 1'b0;
  logic             rst     = 1'b1;
  logic             start   = 1'b0;
  logic [LANES-1:0] out_rise;
  logic [LANES-1:0] out_fall;
  logic [LANES-1:0] bitslip_pulse;
  logic [LANES-1:0] lane_locked;
  logic [LANES-1:0] lane_err;
  logic             busy;
  logic             done;
  logic             fail;

  // Lane model: raw pre-slip pattern, each slip swaps the rise/fall phase.
  logic [LANES-1:0] raw_rise = 2'b11;
  logic [LANES-1:0] raw_fall = 2'b00;
  logic [LANES-1:0] m_slip;
  logic             m_clr = 1'b0;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_done;
    logic [1:0] pulse;
    int         n;
    logic [1:0] locked;
    logic [1:0] err;
    logic       fl;
  } ev_t;

  ev_t exp_q[$];

  always #5 dco_clk = ~dco_clk;

  always_ff @(posedge dco_clk) cyc <= cyc + 1;

  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst)        m_slip <= '0;
    else if (m_clr) m_slip <= '0;
    else            m_slip <= m_slip ^ bitslip_pulse;
  end

  assign out_rise = (raw_rise & ~m_slip) | (raw_fall & m_slip);
  assign out_fall = (raw_fall & ~m_slip) | (raw_rise & m_slip);

  bitslip_align_ctrl #(
    .LANES         (LANES),
    .SETTLE_CYCLES (4),
    .CHECK_CYCLES  (8),
    .MAX_SLIPS     (3),
    .EXP_RISE      (1'b1),
    .EXP_FALL      (1'b0)
  ) dut (
    .dco_clk       (dco_clk),
    .rst           (rst),
    .start         (start),
    .out_rise      (out_rise),
    .out_fall      (out_fall),
    .bitslip_pulse (bitslip_pulse),
    .lane_locked   (lane_locked),
    .lane_err      (lane_err),
    .busy          (busy),
    .done          (done),
    .fail          (fail)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_pulse(input logic [1:0] mask, input int n);
    ev_t e;
    e.is_done = 1'b0; e.pulse = mask; e.n = n; e.locked = '0; e.err = '0; e.fl = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int n, input logic [1:0] locked, input logic [1:0] err,
                           input logic fl);
    ev_t e;
    e.is_done = 1'b1; e.pulse = '0; e.n = n; e.locked = locked; e.err = err; e.fl = fl;
    exp_q.push_back(e);
  endtask

  // t0 = cycle count just after the edge that samples start.
  task automatic do_start();
    @(posedge dco_clk); #1 start = 1'b1;
    @(posedge dco_clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic poke_start();
    @(posedge dco_clk); #1 start = 1'b1;
    @(posedge dco_clk); #1 start = 1'b0;
  endtask

  task automatic clr_model();
    @(posedge dco_clk); #1 m_clr = 1'b1;
    @(posedge dco_clk); #1 m_clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge dco_clk);
    repeat (4) @(negedge dco_clk);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  // Monitor: every pulse cycle and every done rise is an event to match in order.
  initial begin : monitor
    logic done_q;
    ev_t  e;
    done_q = 1'b0;
    forever begin
      @(negedge dco_clk);
      if (!rst && (bitslip_pulse != '0 || (done && !done_q))) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {29'd0, bitslip_pulse, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            chk("done_rise",    {31'd0, done && !done_q}, 32'd1);
            chk("done_latency", cyc - t0, e.n);
            chk("done_locked",  lane_locked, e.locked);
            chk("done_err",     lane_err, e.err);
            chk("done_fail",    fail, e.fl);
            chk("done_busy",    busy, 1'b0);
          end else begin
            chk("pulse_mask",  bitslip_pulse, e.pulse);
            chk("pulse_cycle", cyc - t0, e.n);
          end
        end
      end
      done_q = rst ? 1'b0 : done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge dco_clk);
    chk("rst_pulse",  bitslip_pulse, 2'b00);
    chk("rst_locked", lane_locked, 2'b00);
    chk("rst_err",    lane_err, 2'b00);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_done",   done, 1'b0);
    chk("rst_fail",   fail, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge dco_clk);

    // Both lanes aligned: 2 x (4 settle + 8 check + 1 next).
    push_done(26, 2'b11, 2'b00, 1'b0);
    do_start();
    chk("start_busy", busy, 1'b1);
    wait_drain("aligned");

    // Extra starts while busy must not disturb timing.
    push_done(26, 2'b11, 2'b00, 1'b0);
    do_start();
    repeat (3) @(posedge dco_clk);
    poke_start();
    repeat (12) @(posedge dco_clk);
    poke_start();
    wait_drain("start_busy_ignored");

    // Lane1 inverted: one slip on lane1.
    raw_rise = 2'b01; raw_fall = 2'b10;
    clr_model();
    push_pulse(2'b10, 18);
    push_done(32, 2'b11, 2'b00, 1'b0);
    do_start();
    wait_drain("lane1_inverted");

    // Lane0 stuck at (0,0): three slips then error, lane1 still locks.
    raw_rise = 2'b10; raw_fall = 2'b00;
    clr_model();
    push_pulse(2'b01, 5);
    push_pulse(2'b01, 11);
    push_pulse(2'b01, 17);
    push_done(37, 2'b10, 2'b01, 1'b1);
    do_start();
    wait_drain("lane0_stuck");

    // Restart from DONE clears status on the accepting edge.
    chk("pre_restart_err", lane_err, 2'b01);
    raw_rise = 2'b11; raw_fall = 2'b00;
    clr_model();
    push_done(26, 2'b11, 2'b00, 1'b0);
    do_start();
    chk("restart_locked", lane_locked, 2'b00);
    chk("restart_err",    lane_err, 2'b00);
    chk("restart_done",   done, 1'b0);
    chk("restart_fail",   fail, 1'b0);
    chk("restart_busy",   busy, 1'b1);
    wait_drain("restart");

    // One bad sample at lane0 check cycle 6 (decided at edge 11).
    clr_model();
    push_pulse(2'b01, 11);
    push_pulse(2'b01, 17);
    push_done(44, 2'b11, 2'b00, 1'b0);
    do_start();
    repeat (10) @(posedge dco_clk);
    #1 raw_rise = 2'b10;
    @(posedge dco_clk);
    #1 raw_rise = 2'b11;
    wait_drain("glitch");

    // Reset during lane1 CHECK just before its slip pulse would be registered.
    raw_rise = 2'b01; raw_fall = 2'b10;
    clr_model();
    do_start();
    repeat (17) @(posedge dco_clk);
    @(negedge dco_clk);
    chk("pre_rst_locked", lane_locked, 2'b01);
    rst = 1'b1;
    #1;
    chk("midrst_pulse",  bitslip_pulse, 2'b00);
    chk("midrst_locked", lane_locked, 2'b00);
    chk("midrst_err",    lane_err, 2'b00);
    chk("midrst_busy",   busy, 1'b0);
    chk("midrst_done",   done, 1'b0);
    chk("midrst_fail",   fail, 1'b0);
    @(posedge dco_clk); #1;
    chk("midrst_no_pulse", bitslip_pulse, 2'b00);
    @(negedge dco_clk);
    rst = 1'b0;
    repeat (6) @(negedge dco_clk);
    chk("post_rst_idle_busy", busy, 1'b0);
    chk("post_rst_idle_done", done, 1'b0);
    push_pulse(2'b10, 18);
    push_done(32, 2'b11, 2'b00, 1'b0);
    do_start();
    wait_drain("rerun_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
